// File: rtl/boss_hp_pkg.sv
// Shared boss constants: HP ceiling, phase thresholds, sprite size and the
// health-controller state encoding, also used by the boss movement block.
package boss_hp_pkg;

  localparam int unsigned BOSS_HP_MAX   = 450;
  localparam int unsigned PHASE_HI_TH   = 300;
  localparam int unsigned PHASE_LO_TH   = 150;
  localparam int unsigned BOSS_SPRITE_W = 80;
  localparam int unsigned BOSS_SPRITE_H = 60;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FIGHT    = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;
  localparam logic [1:0] ST_DEAD     = 2'd3;

  typedef enum logic [1:0] {
    PHASE_NONE = 2'd0,
    PHASE_HIGH = 2'd1,
    PHASE_MID  = 2'd2,
    PHASE_LOW  = 2'd3
  } phase_e;

  function automatic phase_e phase_decode(input logic [9:0] hp);
    if (hp > 10'(PHASE_HI_TH))      return PHASE_HIGH;
    else if (hp > 10'(PHASE_LO_TH)) return PHASE_MID;
    else if (hp != 10'd0)           return PHASE_LOW;
    else                            return PHASE_NONE;
  endfunction

endpackage

// File: rtl/boss_hp_hitbox.sv
// Combinational point-in-rectangle test, shared with the small-enemy collision
// logic. Right/bottom edges are exclusive.
module boss_hitbox
  import boss_hp_pkg::*;
(
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [9:0] pt_x,
  input  logic [9:0] pt_y,
  input  logic [9:0] box_w,
  input  logic [9:0] box_h,
  output logic       hit
);

  logic [10:0] right_edge;
  logic [10:0] bottom_edge;
  logic        in_x;
  logic        in_y;

  // 11-bit edges so a box near the screen limit cannot wrap around to zero.
  assign right_edge  = {1'b0, pos_x} + {1'b0, box_w};
  assign bottom_edge = {1'b0, pos_y} + {1'b0, box_h};

  assign in_x = (pt_x >= pos_x) && ({1'b0, pt_x} < right_edge);
  assign in_y = (pt_y >= pos_y) && ({1'b0, pt_y} < bottom_edge);
  assign hit  = in_x && in_y;

endmodule

// File: rtl/boss_hp.sv
// Boss health controller: hit detection, saturating damage, post-hit
// invulnerability window, phase decode and sticky defeat.
module boss_hp
  import boss_hp_pkg::*;
#(
  parameter int unsigned HP_MAX     = BOSS_HP_MAX,
  parameter int unsigned DAMAGE     = 10,
  parameter int unsigned BOSS_W     = BOSS_SPRITE_W,
  parameter int unsigned BOSS_H     = BOSS_SPRITE_H,
  parameter int unsigned COOLDOWN_T = 8
)(
  input  logic       clk22,
  input  logic       rst,
  input  logic       boss,
  input  logic [9:0] bossx,
  input  logic [9:0] bossy,
  input  logic       bullet_valid,
  input  logic [9:0] bulletx,
  input  logic [9:0] bullety,
  output logic [9:0] bosshp,
  output logic       hit_ack,
  output logic [1:0] phase,
  output logic       defeated
);

  localparam logic [9:0] HP_INIT = 10'(HP_MAX);
  localparam logic [9:0] DMG     = 10'(DAMAGE);
  localparam logic [9:0] BOX_W   = 10'(BOSS_W);
  localparam logic [9:0] BOX_H   = 10'(BOSS_H);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_T - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] bosshp_q, bosshp_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hit_ack_q, hit_ack_d;
  logic       in_box;
  logic       hit;
  logic [9:0] hp_sub;

  boss_hitbox u_hitbox (
    .pos_x (bossx),
    .pos_y (bossy),
    .pt_x  (bulletx),
    .pt_y  (bullety),
    .box_w (BOX_W),
    .box_h (BOX_H),
    .hit   (in_box)
  );

  assign hit    = boss && bullet_valid && in_box;
  assign hp_sub = (bosshp_q <= DMG) ? 10'd0 : bosshp_q - DMG;

  always_comb begin
    state_d   = state_q;
    bosshp_d  = bosshp_q;
    cnt_d     = cnt_q;
    hit_ack_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (boss) state_d = ST_FIGHT;
      end
      ST_FIGHT: begin
        if (!boss) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          hit_ack_d = 1'b1;
          bosshp_d  = hp_sub;
          if (hp_sub == 10'd0) begin
            state_d = ST_DEAD;
          end else begin
            cnt_d   = CD_LOAD;
            state_d = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        // Losing the boss abandons the window; the next fight starts fresh.
        if (!boss) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_FIGHT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DEAD: begin
        bosshp_d = 10'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk22) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bosshp_q  <= HP_INIT;
      cnt_q     <= 8'd0;
      hit_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bosshp_q  <= bosshp_d;
      cnt_q     <= cnt_d;
      hit_ack_q <= hit_ack_d;
    end
  end

  assign bosshp   = bosshp_q;
  assign hit_ack  = hit_ack_q;
  assign defeated = (state_q == ST_DEAD);
  assign phase    = ((state_q == ST_FIGHT) || (state_q == ST_COOLDOWN))
                    ? phase_decode(bosshp_q) : PHASE_NONE;

endmodule

// File: tb/tb_boss_hp.sv
// Directed bench for boss_hp: a default instance plus one preloaded to 305 HP,
// both driven from the same stimulus.
module tb_boss_hp;

  logic       clk22 = 1'b0;
  logic       rst = 1'b0;
  logic       boss = 1'b0;
  logic [9:0] bossx = 10'd220;
  logic [9:0] bossy = 10'd75;
  logic       bullet_valid = 1'b0;
  logic [9:0] bulletx = 10'd0;
  logic [9:0] bullety = 10'd0;

  logic [9:0] hp_a, hp_b;
  logic       ack_a, ack_b;
  logic [1:0] ph_a, ph_b;
  logic       def_a, def_b;

  int checks = 0;
  int failures = 0;

  boss_hp dut_a (
    .clk22(clk22), .rst(rst), .boss(boss), .bossx(bossx), .bossy(bossy),
    .bullet_valid(bullet_valid), .bulletx(bulletx), .bullety(bullety),
    .bosshp(hp_a), .hit_ack(ack_a), .phase(ph_a), .defeated(def_a)
  );

  boss_hp #(.HP_MAX(305)) dut_b (
    .clk22(clk22), .rst(rst), .boss(boss), .bossx(bossx), .bossy(bossy),
    .bullet_valid(bullet_valid), .bulletx(bulletx), .bullety(bullety),
    .bosshp(hp_b), .hit_ack(ack_b), .phase(ph_b), .defeated(def_b)
  );

  always #5 clk22 = ~clk22;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       boss;
    logic       bv;
    logic [9:0] ux;
    logic [9:0] uy;
    int         hp_a;
    int         ack;
    int         ph_a;
    int         def;
    int         hp_b;
    int         ph_b;
  } vec_t;

  vec_t vq[$];

  task automatic cmp(input string name, input string what, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s %s got=%0d exp=%0d", name, what, got, exp);
    end
  endtask

  // Drive one tick of inputs and step past the edge that consumes them.
  task automatic applyStimulus(input logic rst_n, input logic b, input logic bv,
                               input logic [9:0] ux, input logic [9:0] uy);
    rst          = rst_n;
    boss         = b;
    bullet_valid = bv;
    bulletx      = ux;
    bullety      = uy;
    @(posedge clk22);
    #1;
  endtask

  task automatic checkOutput(input string name, input int hp, input int ack,
                             input int ph, input int def);
    cmp(name, "a.bosshp", int'(hp_a), hp);
    cmp(name, "a.hit_ack", int'(ack_a), ack);
    cmp(name, "a.phase", int'(ph_a), ph);
    cmp(name, "a.defeated", int'(def_a), def);
  endtask

  task automatic checkB(input string name, input int hp, input int ack,
                        input int ph, input int def);
    cmp(name, "b.bosshp", int'(hp_b), hp);
    cmp(name, "b.hit_ack", int'(ack_b), ack);
    cmp(name, "b.phase", int'(ph_b), ph);
    cmp(name, "b.defeated", int'(def_b), def);
  endtask

  task automatic gapTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
  endtask

  function automatic int phaseOf(input int hp);
    if (hp > 300)      return 1;
    else if (hp > 150) return 2;
    else if (hp > 0)   return 3;
    else               return 0;
  endfunction

  int ma, mb, exp_ack_a, exp_ack_b;

  initial begin
    // name, rst_n, boss, bv, ux, uy, hp_a, ack, ph_a, def, hp_b, ph_b
    vq.push_back('{"reset",         1'b0, 1'b0, 1'b0, 10'd0,    10'd0,    450, 0, 0, 0, 305, 0});
    vq.push_back('{"idle_bul_in",   1'b1, 1'b0, 1'b1, 10'd230,  10'd80,   450, 0, 0, 0, 305, 0});
    vq.push_back('{"idle_bul_org",  1'b1, 1'b0, 1'b1, 10'd0,    10'd0,    450, 0, 0, 0, 305, 0});
    vq.push_back('{"idle_bul_far",  1'b1, 1'b0, 1'b1, 10'd1023, 10'd1023, 450, 0, 0, 0, 305, 0});
    vq.push_back('{"boss_on",       1'b1, 1'b1, 1'b0, 10'd0,    10'd0,    450, 0, 1, 0, 305, 1});
    vq.push_back('{"hit1",          1'b1, 1'b1, 1'b1, 10'd230,  10'd80,   440, 1, 1, 0, 295, 2});
    for (int i = 0; i < 8; i++)
      vq.push_back('{$sformatf("cd_hold%0d", i), 1'b1, 1'b1, 1'b1, 10'd230, 10'd80, 440, 0, 1, 0, 295, 2});
    vq.push_back('{"hit2",          1'b1, 1'b1, 1'b1, 10'd230,  10'd80,   430, 1, 1, 0, 285, 2});
    for (int i = 0; i < 9; i++)
      vq.push_back('{$sformatf("gap%0d", i), 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 430, 0, 1, 0, 285, 2});
    vq.push_back('{"probe_left",    1'b1, 1'b1, 1'b1, 10'd219,  10'd80,   430, 0, 1, 0, 285, 2});
    vq.push_back('{"probe_right",   1'b1, 1'b1, 1'b1, 10'd300,  10'd80,   430, 0, 1, 0, 285, 2});
    vq.push_back('{"probe_bottom",  1'b1, 1'b1, 1'b1, 10'd220,  10'd135,  430, 0, 1, 0, 285, 2});
    vq.push_back('{"probe_corner",  1'b1, 1'b1, 1'b1, 10'd299,  10'd134,  420, 1, 1, 0, 275, 2});

    foreach (vq[i]) begin
      applyStimulus(vq[i].rst_n, vq[i].boss, vq[i].bv, vq[i].ux, vq[i].uy);
      checkOutput(vq[i].name, vq[i].hp_a, vq[i].ack, vq[i].ph_a, vq[i].def);
      checkB(vq[i].name, vq[i].hp_b, vq[i].ack, vq[i].ph_b, vq[i].def);
    end

    // Spaced hits drain both bosses; b saturates 5 -> 0 and both then ignore hits.
    gapTicks(9);
    ma = 420;
    mb = 275;
    for (int k = 0; k < 45; k++) begin
      exp_ack_a = (ma > 0) ? 1 : 0;
      exp_ack_b = (mb > 0) ? 1 : 0;
      if (ma > 0) ma = (ma <= 10) ? 0 : ma - 10;
      if (mb > 0) mb = (mb <= 10) ? 0 : mb - 10;
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd230, 10'd80);
      checkOutput($sformatf("drain%0d", k), ma, exp_ack_a, phaseOf(ma), (ma == 0) ? 1 : 0);
      checkB($sformatf("drain%0d", k), mb, exp_ack_b, phaseOf(mb), (mb == 0) ? 1 : 0);
      gapTicks(9);
    end

    // Boss drop, counter discard and reset priority.
    applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("reset2", 450, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    checkOutput("fight2", 450, 0, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd230, 10'd80);
    checkOutput("fall_with_hit", 450, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    checkOutput("fight3", 450, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd230, 10'd80);
    checkOutput("hit_a", 440, 1, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd230, 10'd80);
    checkOutput("cd_a", 440, 0, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd230, 10'd80);
    checkOutput("reset_in_cd", 450, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    checkOutput("fight4", 450, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd230, 10'd80);
    checkOutput("hit_b", 440, 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd230, 10'd80);
    checkOutput("cd_boss_drop", 440, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    checkOutput("boss_back", 440, 0, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd230, 10'd80);
    checkOutput("immediate_hit", 430, 1, 1, 0);
    gapTicks(9);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd230, 10'd80);
    checkOutput("reset_vs_hit", 450, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 10'd0, 10'd0);
    checkOutput("fight5", 450, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boss_hp.md
# boss_hp

Boss health controller for the boss stage, clocked on the 22-bit divided game tick. It consumes the boss's active flag and position and checks the player bullet against the boss hitbox. On each accepted hit it applies saturating damage, then enforces a post-hit invulnerability window. It produces `bosshp`, which drives the boss movement and activation logic, plus phase and defeat indications for the display and score logic.

## Interface
Parameters:
- `HP_MAX`, 450: HP at reset. Must be ≤ 450 so the boss can activate.
- `DAMAGE`, 10: HP removed per accepted hit.
- `BOSS_W`, 80: hitbox width in pixels.
- `BOSS_H`, 60: hitbox height in pixels.
- `COOLDOWN_T`, 8: invulnerability length in ticks after a hit.

Ports:
- `clk22` in 1: game tick clock. This is the block's only clock.
- `rst` in 1: reset, synchronous and active-low. `rst==0` at a rising edge resets the block.
- `boss` in 1: boss active flag.
- `bossx` in 10: boss top-left x coordinate.
- `bossy` in 10: boss top-left y coordinate.
- `bullet_valid` in 1: a player bullet is in flight.
- `bulletx` in 10: bullet x coordinate.
- `bullety` in 10: bullet y coordinate.
- `bosshp` out 10: current boss HP.
- `hit_ack` out 1: one-tick pulse. It tells the bullet owner to retire the bullet.
- `phase` out 2: 0 = not fighting, 1 = HP > 300, 2 = 300 ≥ HP > 150, 3 = 150 ≥ HP > 0.
- `defeated` out 1: boss HP has reached 0. Sticky until reset.

## Operation
- Hit condition (combinational): `boss && bullet_valid && bulletx >= bossx && bulletx < bossx+BOSS_W && bullety >= bossy && bullety < bossy+BOSS_H`.
  - Sums are formed in 11 bits, so no wrap occurs at the right or bottom edge.
  - Comparisons are unsigned.
- State machine, with states `IDLE`, `FIGHT`, `COOLDOWN` and `DEAD`:
  - `IDLE`: waits for `boss==1`, then goes to `FIGHT`. Hits are ignored.
  - `FIGHT`: on a hit, `bosshp` is reduced by `DAMAGE` (saturating) and `hit_ack` pulses.
    - If the new HP is 0, go to `DEAD`.
    - Otherwise load the cooldown counter with `COOLDOWN_T-1` and go to `COOLDOWN`.
    - If `boss` falls without a hit, go to `IDLE`.
  - `COOLDOWN`: the counter decrements each tick. Hits are ignored, so no damage and no `hit_ack`; the bullet continues.
    - When the counter reaches 0, go to `FIGHT`.
    - If `boss` falls, go to `IDLE`; the counter is discarded.
  - `DEAD`: `bosshp=0` and `defeated=1`. Only reset leaves this state.
- Saturating subtraction: if `bosshp <= DAMAGE`, the next HP is 0; otherwise the next HP is `bosshp - DAMAGE`. HP never underflows.
- `phase` is decoded from the registered `bosshp` whenever the state is not `IDLE` or `DEAD`. It is 0 in `IDLE` and 0 in `DEAD`.

## Timing
- Reset values: `bosshp=HP_MAX`, `hit_ack=0`, `phase=0`, `defeated=0`, state `IDLE`, counter 0.
- Hit latency: a hit that is combinationally true in the tick ending at edge N produces the following at edge N:
  - `bosshp` updated,
  - `hit_ack=1` for exactly one tick,
  - the state change.
- Cooldown: after a hit at edge N, the next hit can be accepted at edge N+`COOLDOWN_T`+1 at the earliest.
- Defeat: `defeated` rises at the same edge that `bosshp` becomes 0. The downstream `boss` flag drops one tick later; this block must tolerate `boss` staying high during that tick.
- A hit on the same tick that `boss` falls is ignored.
- Reset mid-fight or mid-cooldown restores all reset values at that edge. Reset takes priority over a simultaneous hit.
- `bullet_valid` with `boss==0` never acks.

## Structure
- Shared package holds:
  - `BOSS_HP_MAX` (450),
  - the phase thresholds (300 and 150),
  - the default boss sprite width and height,
  - the state encoding localparams.

  The boss movement block uses the same constants.
- One sub-module, `boss_hitbox`, performs the purely combinational rectangle test: inputs are the position, the bullet and the dimensions; output is `hit`. The point-in-box test is reused by the small-enemy collision logic.

## Test plan
- Reset, then release with `boss=0` and bullets everywhere → `bosshp=450`, `phase=0`, `hit_ack` never asserted.
- `boss=1` at (220,75), bullet at (230,80) for one tick → `bosshp=440` and `hit_ack` pulses for one tick. A bullet held steady for 8 more ticks gives no further damage; a hit is accepted again on the 10th tick (`bosshp=430`).
- Edge probes at (219,80), (300,80), (220,135) and (299,134) → only (299,134) hits.
- Preload HP to 305, then apply one hit → `bosshp=295` and `phase` changes from 1 to 2. Repeated spaced hits take HP down to 5, then a further hit → `bosshp=0`, `defeated=1`, state `DEAD`. Later hits are ignored.
- Drive `rst=0` during `COOLDOWN` with a bullet also hitting → `bosshp=450`, `hit_ack=0`, state `IDLE`, `defeated=0`.
